imem_loader: RTL and testbench

Boot-time program loader for the pipelined processor. Accepts a framed byte stream over a valid/ready interface, assembles 16-bit instruction words and writes them sequentially into instruction memory. It holds the processor in hold (`cpu_hold`) until a complete frame passes its checksum. It is the write-side counterpart to the processor's instruction fetch path.

---
 rtl/loader_pkg.sv | 16 +
 rtl/imem_loader.sv | 120 ++++++++++++
 tb/tb_imem_loader.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types for the boot-time instruction memory loader.
package loader_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_HI,
    S_LO,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/imem_loader.sv
// Boot loader: frames a byte stream into 16-bit words, writes them to instruction
// memory and releases the CPU only after the frame checksum matches.
//
// state   | meaning
// S_IDLE  | waiting for sync byte, other bytes dropped
// S_COUNT | next byte is word count N (0 means 256)
// S_HI    | next byte is high byte of a word
// S_LO    | next byte is low byte; word is written
// S_CSUM  | next byte is XOR checksum of all data bytes
// S_DONE  | frame loaded, CPU released; sync byte restarts
// S_ERR   | checksum failed, CPU held; sync byte restarts
module imem_loader
  import loader_pkg::*;
#(
  parameter int          address_size     = 8,
  parameter int          instruction_size = 16,
  parameter logic [7:0]  SYNC_BYTE        = SYNC_BYTE_DEF
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_valid,
  input  logic [7:0]                  in_data,
  output logic                        in_ready,
  output logic                        im_we,
  output logic [address_size-1:0]     im_addr,
  output logic [instruction_size-1:0] im_wdata,
  output logic                        cpu_hold,
  output logic                        load_done,
  output logic                        load_error
);

  state_t                  state, state_nx;
  logic [address_size-1:0] addr_cnt;
  logic [8:0]              words_left;
  logic [7:0]              csum;
  logic [7:0]              hi_byte;
  logic                    is_sync;
  logic                    last_word;
  logic                    csum_ok;

  assign in_ready  = 1'b1;
  assign is_sync   = (in_data == SYNC_BYTE);
  assign last_word = (words_left == 9'd1);
  assign csum_ok   = (in_data == csum);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (in_valid) begin
      case (state)
        S_IDLE, S_DONE, S_ERR: if (is_sync) state_nx = S_COUNT;
        S_COUNT:               state_nx = S_HI;
        S_HI:                  state_nx = S_LO;
        S_LO:                  state_nx = last_word ? S_CSUM : S_HI;
        S_CSUM:                state_nx = csum_ok ? S_DONE : S_ERR;
        default:               state_nx = S_IDLE;
      endcase
    end
  end

  // words_left counts down from N; a zero count byte loads 256
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      addr_cnt   <= '0;
      words_left <= '0;
      csum       <= '0;
      hi_byte    <= '0;
    end else begin
      im_we <= 1'b0;
      if (in_valid) begin
        case (state)
          S_IDLE, S_DONE, S_ERR: begin
            if (is_sync) begin
              cpu_hold   <= 1'b1;
              load_done  <= 1'b0;
              load_error <= 1'b0;
            end
          end
          S_COUNT: begin
            words_left <= {(in_data == 8'h00), in_data};
            addr_cnt   <= '0;
            csum       <= '0;
          end
          S_HI: begin
            hi_byte <= in_data;
            csum    <= csum ^ in_data;
          end
          S_LO: begin
            im_we      <= 1'b1;
            im_addr    <= addr_cnt;
            im_wdata   <= instruction_size'({hi_byte, in_data});
            csum       <= csum ^ in_data;
            addr_cnt   <= addr_cnt + 1'b1;
            words_left <= words_left - 9'd1;
          end
          S_CSUM: begin
            if (csum_ok) begin
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              load_error <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus random frames checked
// against a frame-level model of writes, checksum and status flags.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        im_we;
  logic [7:0]  im_addr;
  logic [15:0] im_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          we_count = 0;
  logic [15:0] tx_words [256];
  logic        exp_hold, exp_done, exp_err;

  imem_loader dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (im_we === 1'b1) we_count <= we_count + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_ready"}, in_ready, 1);
    check({tag, "_hold"}, cpu_hold, exp_hold);
    check({tag, "_done"}, load_done, exp_done);
    check({tag, "_err"}, load_error, exp_err);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_we"}, im_we, 0);
    check({tag, "_addr"}, im_addr, 0);
    check({tag, "_wdata"}, im_wdata, 0);
    exp_hold = 1'b1; exp_done = 1'b0; exp_err = 1'b0;
    check_status(tag);
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int g);
    repeat (g) @(negedge clk);
  endtask

  // flip = 0 sends the correct checksum; any nonzero mask corrupts it
  task automatic send_frame(input int n, input int gap, input logic [7:0] flip);
    logic [7:0] cs;
    logic [7:0] sent;
    int         base;
    bit         ok;
    cs = 8'h00;
    for (int i = 0; i < n; i++) cs = cs ^ tx_words[i][15:8] ^ tx_words[i][7:0];
    sent = cs ^ flip;
    ok   = (sent == cs);
    base = we_count;
    send_byte(8'hA5);
    exp_hold = 1'b1; exp_done = 1'b0; exp_err = 1'b0;
    check_status("sync");
    idle(gap);
    send_byte(n[7:0]);
    check("we_count_byte", im_we, 0);
    idle(gap);
    for (int i = 0; i < n; i++) begin
      send_byte(tx_words[i][15:8]);
      check("we_hi", im_we, 0);
      idle(gap);
      send_byte(tx_words[i][7:0]);
      check("we_lo", im_we, 1);
      check("addr", im_addr, i[7:0]);
      check("wdata", im_wdata, tx_words[i]);
      idle(gap);
    end
    send_byte(sent);
    check("we_csum", im_we, 0);
    exp_done = ok; exp_err = !ok; exp_hold = !ok;
    check_status("csum");
    check("write_total", we_count - base, n);
  endtask

  initial begin
    int          base;
    int          n;
    logic [7:0]  nb;
    reset_n  = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #3 reset_n = 1'b0;
    #1 check_reset_vals("por");
    idle(2);
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_vals("post_rst");

    // nominal frame
    tx_words[0] = 16'h1234; tx_words[1] = 16'h5678;
    send_frame(2, 0, 8'h00);

    // bad checksum: A5 01 AB CD 00
    tx_words[0] = 16'hABCD;
    send_frame(1, 0, 8'h66);

    // noise in ERR, then nominal frame with 3-cycle gaps
    send_byte(8'h00); check_status("noise0");
    send_byte(8'hFF); check_status("noise1");
    send_byte(8'h3C); check_status("noise2");
    tx_words[0] = 16'h1234; tx_words[1] = 16'h5678;
    send_frame(2, 3, 8'h00);

    // full 256-word frame, word i = {i, ~i}
    for (int i = 0; i < 256; i++) tx_words[i] = {i[7:0], ~i[7:0]};
    send_frame(256, 0, 8'h00);

    // reload after DONE, sync arriving right after the checksum byte
    tx_words[0] = 16'hBEEF; tx_words[1] = 16'h0042; tx_words[2] = 16'hC001;
    send_frame(3, 0, 8'h00);

    // reset between HI and LO of word 1
    tx_words[0] = 16'h1111; tx_words[1] = 16'h2222;
    base = we_count;
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h11);
    check("rst_w0_we", im_we, 1);
    send_byte(8'h22);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("mid_rst");
    idle(2);
    reset_n = 1'b1;
    @(negedge clk);
    send_byte(8'h22);
    check("rst_no_we", im_we, 0);
    idle(2);
    check("rst_writes", we_count - base, 1);
    check_reset_vals("after_mid_rst");
    for (int i = 0; i < 256; i++) tx_words[i] = 16'(($urandom & 32'hFFFF));
    send_frame(256, 0, 8'h00);

    // random frames with noise, gaps and occasional corrupted checksums
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
        nb = 8'($urandom_range(0, 255));
        if (nb == 8'hA5) nb = 8'h00;
        send_byte(nb);
        check_status("rnd_noise");
      end
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) tx_words[i] = 16'(($urandom & 32'hFFFF));
      if ($urandom_range(0, 2) == 0) nb = 8'h01 << $urandom_range(0, 7);
      else nb = 8'h00;
      send_frame(n, $urandom_range(0, 2), nb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
